csr_access_arbiter: RTL and testbench

//  Shares the single CSR read/write port of the CSR unit between NUM_REQ requesters
//  (port 0 = core control unit, port 1 = debug module). Arbitrates round-robin, then

---
 rtl/csr_access_arbiter.sv | 129 ++++++++++++
 tb/tb_csr_access_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter that shares the csr_unit read/write port between NUM_REQ requesters.
// Each granted access runs as a fixed IDLE -> RD -> WR -> ACK sequence.
module csr_access_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [12*NUM_REQ-1:0]   req_addr,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic                    busy,
  output logic [11:0]             csr_addr,
  output logic                    csr_wr,
  output logic [1:0]              csr_mode,
  output logic [31:0]             csr_din,
  input  logic [31:0]             csr_dout,
  input  logic                    csr_illegal
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] next_ptr;
  logic          gnt_found;
  logic [PW:0]   cand;
  logic [11:0]   sel_addr;
  logic [1:0]    sel_op;
  logic [31:0]   sel_wdata;
  logic [1:0]    op_l;
  logic [31:0]   rdata_l;
  logic          err_l;
  logic          acc_err;

  // Modifying ops to the read-only CSR space (addr[11:10] == 11) are refused like illegal addresses.
  function automatic logic access_err(input logic illegal, input logic [1:0] op,
                                      input logic [11:0] addr);
    return illegal | ((op != 2'b00) & (addr[11:10] == 2'b11));
  endfunction

  // Scan downward so the requester closest above rr_ptr is the one left selected.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (req[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_op    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr  = req_addr[12*i +: 12];
        sel_op    = req_op[2*i +: 2];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  assign next_ptr = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign acc_err  = access_err(csr_illegal, op_l, csr_addr);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      csr_wr   <= 1'b0;
      csr_addr <= '0;
      csr_mode <= 2'b01;
      csr_din  <= '0;
      op_l     <= '0;
      rdata_l  <= '0;
      err_l    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner    <= gnt_idx;
            rr_ptr   <= next_ptr;
            csr_addr <= sel_addr;
            op_l     <= sel_op;
            csr_mode <= sel_op;
            csr_din  <= sel_wdata;
            state    <= RD;
          end
        end
        RD: begin
          rdata_l <= csr_dout;
          err_l   <= acc_err;
          csr_wr  <= (op_l != 2'b00) && !acc_err;
          state   <= WR;
        end
        WR: begin
          csr_wr     <= 1'b0;
          ack[owner] <= 1'b1;
          rdata      <= rdata_l;
          err        <= err_l;
          state      <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter: a behavioural CSR file plus a per-port expectation
// queue filled at request time and drained by an independent monitor on each ack.
module tb_csr_access_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [12*N-1:0] req_addr = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [31:0]     rdata;
  logic            err;
  logic            busy;
  logic [11:0]     csr_addr;
  logic            csr_wr;
  logic [1:0]      csr_mode;
  logic [31:0]     csr_din;
  logic [31:0]     csr_dout;
  logic            csr_illegal;

  csr_access_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_op(req_op),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .csr_addr(csr_addr), .csr_wr(csr_wr), .csr_mode(csr_mode), .csr_din(csr_din),
    .csr_dout(csr_dout), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [11:0] addr;
    logic [1:0]  mode;
    logic [31:0] din;
  } exp_t;

  logic [31:0] csr_mem [4096];
  logic [31:0] shadow  [4096];
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic is_illegal(input logic [11:0] a);
    return a[11:4] == 8'h7F;
  endfunction

  function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] wd);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  // Behavioural CSR unit: illegal window 0x7F0-0x7FF, writes applied on the clock edge.
  assign csr_dout    = csr_mem[csr_addr];
  assign csr_illegal = is_illegal(csr_addr);
  always @(posedge clk) if (csr_wr) csr_mem[csr_addr] <= apply_op(csr_mode, csr_mem[csr_addr], csr_din);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int p, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd);
    exp_t e;
    e.addr  = a;
    e.mode  = op;
    e.din   = wd;
    e.err   = is_illegal(a) | ((op != 2'b00) && (a[11:10] == 2'b11));
    e.rdata = shadow[a];
    e.wr    = (op != 2'b00) && !e.err;
    if (e.wr) shadow[a] = apply_op(op, shadow[a], wd);
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic drive_port(input int p, input logic [11:0] a, input logic [1:0] op,
                            input logic [31:0] wd);
    req_addr[p*12 +: 12]  = a;
    req_op[p*2 +: 2]      = op;
    req_wdata[p*32 +: 32] = wd;
    req[p]                = 1'b1;
  endtask

  task automatic do_txn(input int p, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input bit drop_early);
    int n;
    push_exp(p, a, op, wd);
    drive_port(p, a, op, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_early && n == 1) req[p] = 1'b0;
    end while (!ack[p] && n < 20);
    check("txn_latency", n, 3);
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [11:0] pick_addr(input int p, input int k);
    logic [11:0] a0 [5];
    logic [11:0] a1 [5];
    a0 = '{12'h340, 12'h341, 12'h7F5, 12'hC00, 12'hF14};
    a1 = '{12'h342, 12'h343, 12'h7F8, 12'hC01, 12'hF11};
    return (p == 0) ? a0[k] : a1[k];
  endfunction

  // Monitor: pops the owning port's expectation on every ack and checks the write it saw.
  logic        wr_seen = 1'b0;
  int          wr_cnt = 0;
  logic [45:0] wr_info = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_seen = 1'b0;
        wr_cnt  = 0;
      end else begin
        check("ack_onehot0", {63'b0, $onehot0(ack)}, 64'd1);
        if (csr_wr) begin
          wr_seen = 1'b1;
          wr_cnt++;
          wr_info = {csr_addr, csr_mode, csr_din};
        end
        for (int p = 0; p < N; p++) begin
          if (ack[p]) begin
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: port %0d acked, expected no ack", p);
            end else begin
              e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check("ack_rdata", rdata, e.rdata);
              check("ack_err", err, e.err);
              check("wr_pulses", wr_cnt, e.wr ? 1 : 0);
              if (e.wr && wr_seen) check("wr_fields", wr_info, {e.addr, e.mode, e.din});
            end
            wr_seen = 1'b0;
            wr_cnt  = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ord [4];
    int          cyc [4];
    int          n;
    int          t;
    int          remaining [2];
    bit          active [2];
    int          delay [2];
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd;

    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      shadow[i]  = csr_mem[i];
    end
    csr_mem[12'hF14] = 32'h0;        shadow[12'hF14] = 32'h0;
    csr_mem[12'h340] = 32'h12345678; shadow[12'h340] = 32'h12345678;
    csr_mem[12'h341] = 32'hAAAA5555; shadow[12'h341] = 32'hAAAA5555;

    do_reset();
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_csr_wr", csr_wr, 0);
    check("rst_csr_addr", csr_addr, 0);
    check("rst_csr_mode", csr_mode, 2'b01);
    check("rst_csr_din", csr_din, 0);
    check("rst_busy", busy, 0);

    do_txn(0, 12'hF14, 2'b00, 32'h0, 0);
    do_txn(0, 12'h340, 2'b01, 32'hDEADBEEF, 0);
    check("mscratch_written", csr_mem[12'h340], 32'hDEADBEEF);
    do_txn(0, 12'h340, 2'b00, 32'h0, 0);
    do_txn(1, 12'hF11, 2'b10, 32'h0000FFFF, 0);
    do_txn(1, 12'hF11, 2'b00, 32'h0, 0);
    do_txn(0, 12'h7FF, 2'b01, 32'h00001234, 0);
    repeat (3) @(negedge clk);
    check("err_hold", err, 1);
    do_txn(1, 12'h342, 2'b11, 32'h0F0F0F0F, 1);

    // Both ports hold req across four back-to-back accesses.
    do_reset();
    push_exp(0, 12'hF14, 2'b00, 32'h0);
    push_exp(0, 12'hF14, 2'b00, 32'h0);
    push_exp(1, 12'hF11, 2'b00, 32'h0);
    push_exp(1, 12'hF11, 2'b00, 32'h0);
    drive_port(0, 12'hF14, 2'b00, 32'h0);
    drive_port(1, 12'hF11, 2'b00, 32'h0);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        ord[n] = ack[1] ? 1 : 0;
        cyc[n] = c;
        n++;
        if (n == 4) req = '0;
      end
    end
    req = '0;
    check("rr_ack_count", n, 4);
    for (int k = 0; k < 4; k++) check("rr_order", ord[k], k % 2);
    for (int k = 1; k < 4; k++) check("rr_spacing", cyc[k] - cyc[k-1], 4);
    @(negedge clk);

    // Reset asserted during the WR cycle of a write.
    drive_port(0, 12'h341, 2'b01, 32'h0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check("abort_wr_before", csr_wr, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_wr_drop", csr_wr, 0);
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_csr_unchanged", csr_mem[12'h341], 32'hAAAA5555);
    push_exp(0, 12'hF14, 2'b00, 32'h0);
    push_exp(1, 12'hF11, 2'b00, 32'h0);
    drive_port(0, 12'hF14, 2'b00, 32'h0);
    drive_port(1, 12'hF11, 2'b00, 32'h0);
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        ord[n] = ack[1] ? 1 : 0;
        n++;
        req = req & ~ack;
      end
    end
    req = '0;
    check("post_reset_acks", n, 2);
    check("post_reset_first", ord[0], 0);
    check("post_reset_second", ord[1], 1);
    @(negedge clk);

    // Randomised concurrent traffic from both ports.
    remaining = '{40, 40};
    active    = '{0, 0};
    delay     = '{0, 0};
    t = 0;
    while (t < 4000 && (remaining[0] + remaining[1] > 0 || active[0] || active[1])) begin
      @(negedge clk);
      t++;
      for (int p = 0; p < N; p++) begin
        if (active[p]) begin
          if (ack[p]) begin
            req[p]    = 1'b0;
            active[p] = 1'b0;
            delay[p]  = $urandom_range(0, 3);
          end
        end else if (remaining[p] > 0) begin
          if (delay[p] > 0) delay[p]--;
          else begin
            a  = pick_addr(p, $urandom_range(0, 4));
            op = 2'($urandom_range(0, 3));
            wd = $urandom;
            push_exp(p, a, op, wd);
            drive_port(p, a, op, wd);
            active[p] = 1'b1;
            remaining[p]--;
          end
        end
      end
    end
    req = '0;
    check("random_drained", remaining[0] + remaining[1] + int'(active[0]) + int'(active[1]), 0);
    repeat (6) @(negedge clk);
    check("queue0_empty", exp_q0.size(), 0);
    check("queue1_empty", exp_q1.size(), 0);
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 5; k++) begin
        a = pick_addr(p, k);
        check("final_csr_value", csr_mem[a], shadow[a]);
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
